nasti_narrower_writer: RTL and testbench
========================================

Name: nasti_narrower_writer

Overview:
Write-path width converter for NASTI. It accepts AW/W bursts on a wide master-side port and reissues them as a single narrower burst on the slave side. Each master W beat is split into one or more slave W beats, and the slave B response is returned to the master. It sits between a wide interconnect and a narrow peripheral or memory port, beside the read-path narrower.

Parameters:
ID_WIDTH, 2, NASTI ID width
ADDR_WIDTH, 32, address width
MASTER_DATA_WIDTH, 64, master-side data width (power of 2, at least SLAVE_DATA_WIDTH)
SLAVE_DATA_WIDTH, 32, slave-side data width
USER_WIDTH, 1, USER field width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
master_aw_{id,addr,len,size,burst,lock,cache,prot,qos,region,user}  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3/4/4/USER_WIDTH  master AW fields
master_aw_valid  in  1 ; master_aw_ready  out  1
master_w_data  in  MASTER_DATA_WIDTH ; master_w_strb  in  MASTER_DATA_WIDTH/8
master_w_last  in  1 ; master_w_user  in  USER_WIDTH ; master_w_valid  in  1 ; master_w_ready  out  1
master_b_id  out  ID_WIDTH ; master_b_resp  out  2 ; master_b_user  out  USER_WIDTH ; master_b_valid  out  1 ; master_b_ready  in  1
slave_aw_{id,addr,len,size,burst,lock,cache,prot,qos,region,user}  out  same widths as master AW fields
slave_aw_valid  out  1 ; slave_aw_ready  in  1
slave_w_data  out  SLAVE_DATA_WIDTH ; slave_w_strb  out  SLAVE_DATA_WIDTH/8
slave_w_last  out  1 ; slave_w_user  out  USER_WIDTH ; slave_w_valid  out  1 ; slave_w_ready  in  1
slave_b_id  in  ID_WIDTH ; slave_b_resp  in  2 ; slave_b_user  in  USER_WIDTH ; slave_b_valid  in  1 ; slave_b_ready  out  1

Behaviour:
Constants and derived values:
- MCS = log2(MASTER_DATA_WIDTH/8); SCS = log2(SLAVE_DATA_WIDTH/8).
- R = size>SCS ? 1<<(size-SCS) : 1. off = size>SCS ? size-SCS : 0. step = size>SCS ? SLAVE_DATA_WIDTH/8 : 1<<size.
- idx = (addr>>SCS) & (R-1).

State machine (IDLE, AW, W, B); reset to IDLE:
- IDLE: master_aw_ready=1. On AW handshake, latch all AW fields, set w_addr=master_aw_addr and slave beat counter=0, then go to AW.
- AW: slave_aw_valid=1. Slave AW fields are the latched values except:
  - slave_aw_len = R>1 ? ((len+1)<<off) - idx - 1 : len, truncated to 8 bits.
  - slave_aw_size = min(size, SCS).
  - On handshake, go to W.
- W: one-entry master beat buffer (data, strb, user, buf_valid).
  - master_w_ready = (state==W) && !buf_valid. A master W handshake loads the buffer next cycle.
  - slave_w_valid = buf_valid.
  - lane = w_addr[MCS-1:SCS]. slave_w_data = buf_data[lane*SLAVE_DATA_WIDTH +: SLAVE_DATA_WIDTH]; slave_w_strb is the corresponding strb slice; slave_w_user = buf_user.
  - slave_w_last = (slave beat counter == slave_aw_len).
  - On each slave W handshake:
    - counter +1.
    - w_addr <= ((w_addr>>off)<<off) + step. This realigns an unaligned first beat.
    - buf_valid clears when (w_addr & ((1<<size)-1)) + step >= (1<<size), i.e. the last slice of the master beat was sent.
  - After the handshake with slave_w_last=1, go to B.
- B: slave_b_ready = (state==B) && !master_b_valid.
  - A slave B handshake registers id/resp/user into master_b_* and sets master_b_valid.
  - A master B handshake clears master_b_valid and returns to IDLE.
- Only one burst is outstanding. master_aw_ready=0 outside IDLE, and master_w_ready=0 outside W.

Handshake and stability rules:
- Slave W outputs are held stable while slave_w_valid && !slave_w_ready.
- master_b_* are held stable while master_b_valid && !master_b_ready.
- Load and drain of the buffer never coincide: load requires buf_valid=0.

Reset values: master_aw_ready=1 after reset (IDLE); master_w_ready=0, slave_aw_valid=0, slave_w_valid=0, master_b_valid=0, slave_b_ready=0; buffer and counter cleared.

Reset mid-operation: rst asserted in any state forces IDLE immediately (asynchronous) and drops all valids. The in-flight burst is abandoned.

Simulation assertions (fatal):
- burst!=INCR.
- (1<<size)*(len+1) > 32*SLAVE_DATA_WIDTH.
- master_w_last != 1 on the final master beat, or master_w_last == 1 early.
- size > MCS.

slave_b_resp is forwarded unchanged, including non-OKAY responses.

Test Plan:
- Aligned wide write, MASTER 64/SLAVE 32: AW addr 0x1000, len 1, size 3; W 0xAAAA_AAAA_BBBB_BBBB, 0xCCCC_CCCC_DDDD_DDDD, strb 0xFF -> slave AW len 3 size 2; slave W 0xBBBBBBBB, 0xAAAAAAAA, 0xDDDDDDDD, 0xCCCCCCCC with strb 0xF; last only on beat 4; B OKAY forwarded.
- Unaligned: AW addr 0x1004, len 0, size 3; W strb 0xF0, data 0x1234_5678_0000_0000 -> slave len 0; one slave beat 0x12345678, strb 0xF, last=1.
- Narrow: AW addr 0x2004, len 1, size 2; W beats X then Y -> slave len 1 size 2; beat 1 from lane 1, beat 2 from lane 0 (addr 0x2008); each master beat consumed after one slave beat.
- Backpressure: slave_w_ready low 5 cycles mid-burst -> slave_w_data/strb/last stable; master_w_ready stays 0 while buffer full; no beat lost or duplicated.
- Error response: slave B resp=2, master_b_ready low 3 cycles -> master_b_resp=2 held; IDLE and master_aw_ready=1 only after the master B handshake.
- Reset: rst pulsed during W after 1 of 4 slave beats -> all valids 0 asynchronously; master_aw_ready=1 after release; next burst has counter restarted at 0.

Source files
------------

// File: rtl/nasti_narrower_writer.sv
// NASTI write-path width converter: one wide master burst is reissued as a single
// narrower slave burst, each master W beat split into one or more slave W beats.
module nasti_narrower_writer #(
  parameter int ID_WIDTH          = 2,
  parameter int ADDR_WIDTH        = 32,
  parameter int MASTER_DATA_WIDTH = 64,
  parameter int SLAVE_DATA_WIDTH  = 32,
  parameter int USER_WIDTH        = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ID_WIDTH-1:0]            master_aw_id,
  input  logic [ADDR_WIDTH-1:0]          master_aw_addr,
  input  logic [7:0]                     master_aw_len,
  input  logic [2:0]                     master_aw_size,
  input  logic [1:0]                     master_aw_burst,
  input  logic                           master_aw_lock,
  input  logic [3:0]                     master_aw_cache,
  input  logic [2:0]                     master_aw_prot,
  input  logic [3:0]                     master_aw_qos,
  input  logic [3:0]                     master_aw_region,
  input  logic [USER_WIDTH-1:0]          master_aw_user,
  input  logic                           master_aw_valid,
  output logic                           master_aw_ready,
  input  logic [MASTER_DATA_WIDTH-1:0]   master_w_data,
  input  logic [MASTER_DATA_WIDTH/8-1:0] master_w_strb,
  input  logic                           master_w_last,
  input  logic [USER_WIDTH-1:0]          master_w_user,
  input  logic                           master_w_valid,
  output logic                           master_w_ready,
  output logic [ID_WIDTH-1:0]            master_b_id,
  output logic [1:0]                     master_b_resp,
  output logic [USER_WIDTH-1:0]          master_b_user,
  output logic                           master_b_valid,
  input  logic                           master_b_ready,
  output logic [ID_WIDTH-1:0]            slave_aw_id,
  output logic [ADDR_WIDTH-1:0]          slave_aw_addr,
  output logic [7:0]                     slave_aw_len,
  output logic [2:0]                     slave_aw_size,
  output logic [1:0]                     slave_aw_burst,
  output logic                           slave_aw_lock,
  output logic [3:0]                     slave_aw_cache,
  output logic [2:0]                     slave_aw_prot,
  output logic [3:0]                     slave_aw_qos,
  output logic [3:0]                     slave_aw_region,
  output logic [USER_WIDTH-1:0]          slave_aw_user,
  output logic                           slave_aw_valid,
  input  logic                           slave_aw_ready,
  output logic [SLAVE_DATA_WIDTH-1:0]    slave_w_data,
  output logic [SLAVE_DATA_WIDTH/8-1:0]  slave_w_strb,
  output logic                           slave_w_last,
  output logic [USER_WIDTH-1:0]          slave_w_user,
  output logic                           slave_w_valid,
  input  logic                           slave_w_ready,
  input  logic [ID_WIDTH-1:0]            slave_b_id,
  input  logic [1:0]                     slave_b_resp,
  input  logic [USER_WIDTH-1:0]          slave_b_user,
  input  logic                           slave_b_valid,
  output logic                           slave_b_ready,
  output logic [1:0]                     dbg_state
);

  localparam int SBYTES = SLAVE_DATA_WIDTH / 8;
  localparam int MCS    = $clog2(MASTER_DATA_WIDTH / 8);
  localparam int SCS    = $clog2(SBYTES);
  localparam int RATIO  = MASTER_DATA_WIDTH / SLAVE_DATA_WIDTH;
  localparam int LW     = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [2:0] SCS_L = SCS[2:0];
  localparam logic [2:0] MCS_L = MCS[2:0];

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t                         state;
  logic [ID_WIDTH-1:0]            aw_id;
  logic [ADDR_WIDTH-1:0]          aw_addr;
  logic [7:0]                     aw_len;
  logic [2:0]                     aw_size;
  logic [1:0]                     aw_burst;
  logic                           aw_lock;
  logic [3:0]                     aw_cache;
  logic [2:0]                     aw_prot;
  logic [3:0]                     aw_qos;
  logic [3:0]                     aw_region;
  logic [USER_WIDTH-1:0]          aw_user;
  logic [7:0]                     s_len;
  logic [2:0]                     s_size;
  logic [ADDR_WIDTH-1:0]          w_addr;
  logic [7:0]                     beat_cnt;
  logic [MASTER_DATA_WIDTH-1:0]   buf_data;
  logic [MASTER_DATA_WIDTH/8-1:0] buf_strb;
  logic [USER_WIDTH-1:0]          buf_user;
  logic                           buf_valid;
  logic [ID_WIDTH-1:0]            b_id;
  logic [1:0]                     b_resp;
  logic [USER_WIDTH-1:0]          b_user;
  logic                           b_valid;

  // Slave beat count for a burst: an unaligned start skips the lanes below idx.
  function automatic logic [7:0] calc_slave_len(input logic [ADDR_WIDTH-1:0] addr,
                                                input logic [7:0] len,
                                                input logic [2:0] size);
    logic [2:0]  off;
    logic [15:0] ratio;
    logic [15:0] idx;
    logic [15:0] total;
    off   = 3'd0;
    ratio = 16'd1;
    idx   = 16'd0;
    total = {8'd0, len};
    if (size > SCS_L) begin
      off   = size - SCS_L;
      ratio = 16'd1 << off;
      idx   = 16'(addr >> SCS) & (ratio - 16'd1);
      total = (({8'd0, len} + 16'd1) << off) - idx - 16'd1;
    end
    return total[7:0];
  endfunction

  logic [2:0]            off;
  logic [7:0]            step;
  logic [7:0]            size_mask;
  logic [8:0]            size_bytes;
  logic [8:0]            slice_end;
  logic                  last_slice;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [LW-1:0]         lane;
  logic                  w_hs;

  assign off         = (aw_size > SCS_L) ? (aw_size - SCS_L) : 3'd0;
  assign step        = (aw_size > SCS_L) ? 8'(SBYTES) : (8'd1 << aw_size);
  assign size_mask   = (8'd1 << aw_size) - 8'd1;
  assign size_bytes  = 9'd1 << aw_size;
  assign slice_end   = {1'b0, w_addr[7:0] & size_mask} + {1'b0, step};
  assign last_slice  = slice_end >= size_bytes;
  assign w_addr_next = ((w_addr >> off) << off) + ADDR_WIDTH'(step);
  assign w_hs        = buf_valid && slave_w_ready;

  if (RATIO > 1) begin : g_lane
    assign lane = w_addr[SCS +: LW];
  end else begin : g_lane1
    assign lane = '0;
  end

  logic [SLAVE_DATA_WIDTH-1:0]   data_slice [RATIO];
  logic [SLAVE_DATA_WIDTH/8-1:0] strb_slice [RATIO];
  for (genvar g = 0; g < RATIO; g++) begin : g_slice
    assign data_slice[g] = buf_data[g*SLAVE_DATA_WIDTH +: SLAVE_DATA_WIDTH];
    assign strb_slice[g] = buf_strb[g*SBYTES +: SBYTES];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      aw_id     <= '0;
      aw_addr   <= '0;
      aw_len    <= '0;
      aw_size   <= '0;
      aw_burst  <= '0;
      aw_lock   <= 1'b0;
      aw_cache  <= '0;
      aw_prot   <= '0;
      aw_qos    <= '0;
      aw_region <= '0;
      aw_user   <= '0;
      s_len     <= '0;
      s_size    <= '0;
      w_addr    <= '0;
      beat_cnt  <= '0;
      buf_data  <= '0;
      buf_strb  <= '0;
      buf_user  <= '0;
      buf_valid <= 1'b0;
      b_id      <= '0;
      b_resp    <= '0;
      b_user    <= '0;
      b_valid   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (master_aw_valid) begin
            aw_id     <= master_aw_id;
            aw_addr   <= master_aw_addr;
            aw_len    <= master_aw_len;
            aw_size   <= master_aw_size;
            aw_burst  <= master_aw_burst;
            aw_lock   <= master_aw_lock;
            aw_cache  <= master_aw_cache;
            aw_prot   <= master_aw_prot;
            aw_qos    <= master_aw_qos;
            aw_region <= master_aw_region;
            aw_user   <= master_aw_user;
            s_len     <= calc_slave_len(master_aw_addr, master_aw_len, master_aw_size);
            s_size    <= (master_aw_size > SCS_L) ? SCS_L : master_aw_size;
            w_addr    <= master_aw_addr;
            beat_cnt  <= '0;
            state     <= S_AW;
          end
        end
        S_AW: begin
          if (slave_aw_ready) state <= S_W;
        end
        S_W: begin
          // Load needs an empty buffer, drain needs a full one: never both in a cycle.
          if (master_w_valid && !buf_valid) begin
            buf_data  <= master_w_data;
            buf_strb  <= master_w_strb;
            buf_user  <= master_w_user;
            buf_valid <= 1'b1;
          end
          if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            w_addr   <= w_addr_next;
            if (last_slice || slave_w_last) buf_valid <= 1'b0;
            if (slave_w_last) state <= S_B;
          end
        end
        S_B: begin
          if (slave_b_valid && !b_valid) begin
            b_id    <= slave_b_id;
            b_resp  <= slave_b_resp;
            b_user  <= slave_b_user;
            b_valid <= 1'b1;
          end
          if (b_valid && master_b_ready) begin
            b_valid <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Every channel transfers on a rising edge where valid and ready are both high;
  // a raised valid and its payload stay unchanged until that transfer happens.
  assign master_aw_ready = (state == S_IDLE);
  assign master_w_ready  = (state == S_W) && !buf_valid;
  assign slave_aw_valid  = (state == S_AW);
  assign slave_w_valid   = buf_valid;
  assign slave_b_ready   = (state == S_B) && !b_valid;
  assign master_b_valid  = b_valid;
  assign master_b_id     = b_id;
  assign master_b_resp   = b_resp;
  assign master_b_user   = b_user;
  assign dbg_state       = state;

  assign slave_aw_id     = aw_id;
  assign slave_aw_addr   = aw_addr;
  assign slave_aw_len    = s_len;
  assign slave_aw_size   = s_size;
  assign slave_aw_burst  = aw_burst;
  assign slave_aw_lock   = aw_lock;
  assign slave_aw_cache  = aw_cache;
  assign slave_aw_prot   = aw_prot;
  assign slave_aw_qos    = aw_qos;
  assign slave_aw_region = aw_region;
  assign slave_aw_user   = aw_user;

  assign slave_w_data    = data_slice[lane];
  assign slave_w_strb    = strb_slice[lane];
  assign slave_w_user    = buf_user;
  assign slave_w_last    = (beat_cnt == s_len);

`ifndef SYNTHESIS
  logic [7:0] m_beats;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_beats <= '0;
    end else begin
      if (master_aw_valid && master_aw_ready) begin
        assert (master_aw_burst == 2'b01)
          else $fatal(1, "nasti_narrower_writer: only INCR bursts are supported");
        assert (master_aw_size <= MCS_L)
          else $fatal(1, "nasti_narrower_writer: size wider than master bus");
        assert (((32'd1 << master_aw_size) * ({24'd0, master_aw_len} + 32'd1)) <= 32'(32 * SLAVE_DATA_WIDTH))
          else $fatal(1, "nasti_narrower_writer: burst too long");
        m_beats <= '0;
      end
      if (master_w_valid && master_w_ready) begin
        assert (master_w_last == (m_beats == aw_len))
          else $fatal(1, "nasti_narrower_writer: master_w_last misplaced");
        m_beats <= m_beats + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_nasti_narrower_writer.sv
// Directed bench for nasti_narrower_writer: drivers push expected slave AW/W and master B
// items into queues, a negedge monitor pops and compares them on every handshake.
module tb_nasti_narrower_writer;

  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  master_aw_id;
  logic [31:0] master_aw_addr;
  logic [7:0]  master_aw_len;
  logic [2:0]  master_aw_size;
  logic [1:0]  master_aw_burst;
  logic        master_aw_lock;
  logic [3:0]  master_aw_cache;
  logic [2:0]  master_aw_prot;
  logic [3:0]  master_aw_qos;
  logic [3:0]  master_aw_region;
  logic [0:0]  master_aw_user;
  logic        master_aw_valid;
  logic        master_aw_ready;
  logic [63:0] master_w_data;
  logic [7:0]  master_w_strb;
  logic        master_w_last;
  logic [0:0]  master_w_user;
  logic        master_w_valid;
  logic        master_w_ready;
  logic [1:0]  master_b_id;
  logic [1:0]  master_b_resp;
  logic [0:0]  master_b_user;
  logic        master_b_valid;
  logic        master_b_ready;
  logic [1:0]  slave_aw_id;
  logic [31:0] slave_aw_addr;
  logic [7:0]  slave_aw_len;
  logic [2:0]  slave_aw_size;
  logic [1:0]  slave_aw_burst;
  logic        slave_aw_lock;
  logic [3:0]  slave_aw_cache;
  logic [2:0]  slave_aw_prot;
  logic [3:0]  slave_aw_qos;
  logic [3:0]  slave_aw_region;
  logic [0:0]  slave_aw_user;
  logic        slave_aw_valid;
  logic        slave_aw_ready;
  logic [31:0] slave_w_data;
  logic [3:0]  slave_w_strb;
  logic        slave_w_last;
  logic [0:0]  slave_w_user;
  logic        slave_w_valid;
  logic        slave_w_ready;
  logic [1:0]  slave_b_id;
  logic [1:0]  slave_b_resp;
  logic [0:0]  slave_b_user;
  logic        slave_b_valid;
  logic        slave_b_ready;
  logic [1:0]  dbg_state;

  nasti_narrower_writer dut (
    .clk(clk), .rst(rst),
    .master_aw_id(master_aw_id), .master_aw_addr(master_aw_addr), .master_aw_len(master_aw_len),
    .master_aw_size(master_aw_size), .master_aw_burst(master_aw_burst), .master_aw_lock(master_aw_lock),
    .master_aw_cache(master_aw_cache), .master_aw_prot(master_aw_prot), .master_aw_qos(master_aw_qos),
    .master_aw_region(master_aw_region), .master_aw_user(master_aw_user),
    .master_aw_valid(master_aw_valid), .master_aw_ready(master_aw_ready),
    .master_w_data(master_w_data), .master_w_strb(master_w_strb), .master_w_last(master_w_last),
    .master_w_user(master_w_user), .master_w_valid(master_w_valid), .master_w_ready(master_w_ready),
    .master_b_id(master_b_id), .master_b_resp(master_b_resp), .master_b_user(master_b_user),
    .master_b_valid(master_b_valid), .master_b_ready(master_b_ready),
    .slave_aw_id(slave_aw_id), .slave_aw_addr(slave_aw_addr), .slave_aw_len(slave_aw_len),
    .slave_aw_size(slave_aw_size), .slave_aw_burst(slave_aw_burst), .slave_aw_lock(slave_aw_lock),
    .slave_aw_cache(slave_aw_cache), .slave_aw_prot(slave_aw_prot), .slave_aw_qos(slave_aw_qos),
    .slave_aw_region(slave_aw_region), .slave_aw_user(slave_aw_user),
    .slave_aw_valid(slave_aw_valid), .slave_aw_ready(slave_aw_ready),
    .slave_w_data(slave_w_data), .slave_w_strb(slave_w_strb), .slave_w_last(slave_w_last),
    .slave_w_user(slave_w_user), .slave_w_valid(slave_w_valid), .slave_w_ready(slave_w_ready),
    .slave_b_id(slave_b_id), .slave_b_resp(slave_b_resp), .slave_b_user(slave_b_user),
    .slave_b_valid(slave_b_valid), .slave_b_ready(slave_b_ready),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [53:0] exp_aw_q[$];
  logic [37:0] exp_w_q[$];
  logic [4:0]  exp_b_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    $display("FAIL timeout %s: not reached within %0d cycles at %0t", name, TMO, $time);
  endtask

  function automatic logic [53:0] aw_exp(input logic [1:0] id, input logic [31:0] addr,
                                         input logic [7:0] len, input logic [2:0] size);
    return {id, addr, len, size, 2'b01, 4'h3, 3'h2};
  endfunction

  function automatic logic [37:0] w_exp(input logic [31:0] d, input logic [3:0] s,
                                        input logic l, input logic u);
    return {d, s, l, u};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (slave_aw_valid && slave_aw_ready) begin
        if (exp_aw_q.size() == 0) check("slave_aw_unexpected", 64'd1, 64'd0);
        else check("slave_aw", {slave_aw_id, slave_aw_addr, slave_aw_len, slave_aw_size,
                                slave_aw_burst, slave_aw_cache, slave_aw_prot}, exp_aw_q.pop_front());
      end
      if (slave_w_valid && slave_w_ready) begin
        if (exp_w_q.size() == 0) check("slave_w_unexpected", 64'd1, 64'd0);
        else check("slave_w", {slave_w_data, slave_w_strb, slave_w_last, slave_w_user},
                   exp_w_q.pop_front());
      end
      if (master_b_valid && master_b_ready) begin
        if (exp_b_q.size() == 0) check("master_b_unexpected", 64'd1, 64'd0);
        else check("master_b", {master_b_id, master_b_resp, master_b_user}, exp_b_q.pop_front());
      end
    end
  end

  // drivers
  task automatic do_aw(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size);
    int n;
    master_aw_id = id; master_aw_addr = addr; master_aw_len = len; master_aw_size = size;
    master_aw_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!master_aw_ready && n < TMO);
    if (!master_aw_ready) tmo("master_aw");
    @(posedge clk); #1;
    master_aw_valid = 1'b0;
  endtask

  task automatic do_w(input logic [63:0] data, input logic [7:0] strb, input logic last,
                      input logic user);
    int n;
    master_w_data = data; master_w_strb = strb; master_w_last = last; master_w_user = user;
    master_w_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!master_w_ready && n < TMO);
    if (!master_w_ready) tmo("master_w");
    @(posedge clk); #1;
    master_w_valid = 1'b0;
  endtask

  task automatic slave_run(input int nbeats, input int stall_at, input int stall_len,
                           input logic [1:0] bid, input logic [1:0] bresp, input logic buser,
                           input bit do_b);
    int n;
    logic [37:0] held;
    slave_aw_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!slave_aw_valid && n < TMO);
    if (!slave_aw_valid) tmo("slave_aw");
    @(posedge clk); #1;
    slave_aw_ready = 1'b0;
    slave_w_ready = 1'b1;
    for (int i = 0; i < nbeats; i++) begin
      if (i == stall_at) begin
        slave_w_ready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!slave_w_valid && n < TMO);
        if (!slave_w_valid) tmo("stall_valid");
        held = {slave_w_data, slave_w_strb, slave_w_last, slave_w_user};
        repeat (stall_len) begin
          @(negedge clk);
          check("stall_w_hold", {slave_w_valid, slave_w_data, slave_w_strb, slave_w_last, slave_w_user},
                {1'b1, held});
          check("stall_master_w_ready", {63'd0, master_w_ready}, 64'd0);
        end
        @(posedge clk); #1;
        slave_w_ready = 1'b1;
      end
      n = 0;
      do begin @(negedge clk); n++; end while (!(slave_w_valid && slave_w_ready) && n < TMO);
      if (!(slave_w_valid && slave_w_ready)) tmo("slave_w");
      @(posedge clk); #1;
    end
    slave_w_ready = 1'b0;
    if (do_b) begin
      slave_b_id = bid; slave_b_resp = bresp; slave_b_user = buser;
      slave_b_valid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!slave_b_ready && n < TMO);
      if (!slave_b_ready) tmo("slave_b");
      @(posedge clk); #1;
      slave_b_valid = 1'b0;
    end
  endtask

  task automatic master_b(input int delay);
    int n;
    logic [4:0] held;
    master_b_ready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!master_b_valid && n < TMO);
    if (!master_b_valid) tmo("master_b_valid");
    held = {master_b_id, master_b_resp, master_b_user};
    repeat (delay) begin
      @(negedge clk);
      check("b_hold", {master_b_valid, master_b_id, master_b_resp, master_b_user}, {1'b1, held});
      check("aw_ready_in_b", {63'd0, master_aw_ready}, 64'd0);
    end
    @(posedge clk); #1;
    master_b_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(master_b_valid && master_b_ready) && n < TMO);
    if (!(master_b_valid && master_b_ready)) tmo("master_b_hs");
    @(posedge clk); #1;
    master_b_ready = 1'b0;
    @(negedge clk);
    check("aw_ready_after_b", {63'd0, master_aw_ready}, 64'd1);
  endtask

  task automatic gap();
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {master_aw_ready, master_w_ready, slave_aw_valid, slave_w_valid,
                 master_b_valid, slave_b_ready, dbg_state}, {1'b1, 5'b00000, 2'd0});
  endtask

  initial begin
    rst = 1'b1;
    master_aw_id = '0; master_aw_addr = '0; master_aw_len = '0; master_aw_size = '0;
    master_aw_burst = 2'b01; master_aw_lock = 1'b0; master_aw_cache = 4'h3; master_aw_prot = 3'h2;
    master_aw_qos = 4'h5; master_aw_region = 4'h0; master_aw_user = 1'b0; master_aw_valid = 1'b0;
    master_w_data = '0; master_w_strb = '0; master_w_last = 1'b0; master_w_user = 1'b0;
    master_w_valid = 1'b0; master_b_ready = 1'b0;
    slave_aw_ready = 1'b0; slave_w_ready = 1'b0;
    slave_b_id = '0; slave_b_resp = '0; slave_b_user = '0; slave_b_valid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset_state");
    @(posedge clk); #1;
    rst = 1'b0;
    gap();

    // aligned 64 -> 32
    exp_aw_q.push_back(aw_exp(2'd1, 32'h1000, 8'd3, 3'd2));
    exp_w_q.push_back(w_exp(32'hBBBBBBBB, 4'hF, 1'b0, 1'b0));
    exp_w_q.push_back(w_exp(32'hAAAAAAAA, 4'hF, 1'b0, 1'b0));
    exp_w_q.push_back(w_exp(32'hDDDDDDDD, 4'hF, 1'b0, 1'b1));
    exp_w_q.push_back(w_exp(32'hCCCCCCCC, 4'hF, 1'b1, 1'b1));
    exp_b_q.push_back({2'd1, 2'd0, 1'b0});
    fork
      begin
        do_aw(2'd1, 32'h1000, 8'd1, 3'd3);
        do_w(64'hAAAAAAAA_BBBBBBBB, 8'hFF, 1'b0, 1'b0);
        do_w(64'hCCCCCCCC_DDDDDDDD, 8'hFF, 1'b1, 1'b1);
      end
      slave_run(4, -1, 0, 2'd1, 2'd0, 1'b0, 1'b1);
      master_b(0);
    join
    gap();

    // unaligned start in the upper lane
    exp_aw_q.push_back(aw_exp(2'd0, 32'h1004, 8'd0, 3'd2));
    exp_w_q.push_back(w_exp(32'h12345678, 4'hF, 1'b1, 1'b0));
    exp_b_q.push_back({2'd0, 2'd0, 1'b0});
    fork
      begin
        do_aw(2'd0, 32'h1004, 8'd0, 3'd3);
        do_w(64'h12345678_00000000, 8'hF0, 1'b1, 1'b0);
      end
      slave_run(1, -1, 0, 2'd0, 2'd0, 1'b0, 1'b1);
      master_b(0);
    join
    gap();

    // narrow size-2 burst: one slave beat per master beat, lane 1 then lane 0
    exp_aw_q.push_back(aw_exp(2'd1, 32'h2004, 8'd1, 3'd2));
    exp_w_q.push_back(w_exp(32'h0BAD0001, 4'hF, 1'b0, 1'b1));
    exp_w_q.push_back(w_exp(32'h77778888, 4'hF, 1'b1, 1'b0));
    exp_b_q.push_back({2'd1, 2'd0, 1'b0});
    fork
      begin
        do_aw(2'd1, 32'h2004, 8'd1, 3'd2);
        do_w(64'h0BAD0001_CAFE0001, 8'hF0, 1'b0, 1'b1);
        do_w(64'h55556666_77778888, 8'h0F, 1'b1, 1'b0);
      end
      slave_run(2, -1, 0, 2'd1, 2'd0, 1'b0, 1'b1);
      master_b(0);
    join
    gap();

    // slave W backpressure for 5 cycles on the second slave beat
    exp_aw_q.push_back(aw_exp(2'd0, 32'h3000, 8'd3, 3'd2));
    exp_w_q.push_back(w_exp(32'h89ABCDEF, 4'h3, 1'b0, 1'b0));
    exp_w_q.push_back(w_exp(32'h01234567, 4'hF, 1'b0, 1'b0));
    exp_w_q.push_back(w_exp(32'h76543210, 4'hF, 1'b0, 1'b1));
    exp_w_q.push_back(w_exp(32'hFEDCBA98, 4'hF, 1'b1, 1'b1));
    exp_b_q.push_back({2'd0, 2'd0, 1'b0});
    fork
      begin
        do_aw(2'd0, 32'h3000, 8'd1, 3'd3);
        do_w(64'h01234567_89ABCDEF, 8'hF3, 1'b0, 1'b0);
        do_w(64'hFEDCBA98_76543210, 8'hFF, 1'b1, 1'b1);
      end
      slave_run(4, 1, 5, 2'd0, 2'd0, 1'b0, 1'b1);
      master_b(0);
    join
    gap();

    // SLVERR forwarded, master B held off for 3 cycles
    exp_aw_q.push_back(aw_exp(2'd2, 32'h4000, 8'd0, 3'd2));
    exp_w_q.push_back(w_exp(32'hDEADBEEF, 4'hF, 1'b1, 1'b0));
    exp_b_q.push_back({2'd2, 2'd2, 1'b1});
    fork
      begin
        do_aw(2'd2, 32'h4000, 8'd0, 3'd2);
        do_w(64'h00000000_DEADBEEF, 8'h0F, 1'b1, 1'b0);
      end
      slave_run(1, -1, 0, 2'd2, 2'd2, 1'b1, 1'b1);
      master_b(3);
    join
    gap();

    // reset after one of four slave beats
    exp_aw_q.push_back(aw_exp(2'd1, 32'h5000, 8'd3, 3'd2));
    exp_w_q.push_back(w_exp(32'h33334444, 4'hF, 1'b0, 1'b1));
    fork
      begin
        do_aw(2'd1, 32'h5000, 8'd1, 3'd3);
        do_w(64'h11112222_33334444, 8'hFF, 1'b0, 1'b1);
      end
      slave_run(1, -1, 0, 2'd0, 2'd0, 1'b0, 1'b0);
    join
    check("pre_reset_w_valid", {63'd0, slave_w_valid}, 64'd1);
    #3;
    rst = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_reset_release");
    gap();

    // next burst after reset: beat counter restarted, last only on beat 4
    exp_aw_q.push_back(aw_exp(2'd3, 32'h6000, 8'd3, 3'd2));
    exp_w_q.push_back(w_exp(32'h0FEDCBA9, 4'hF, 1'b0, 1'b0));
    exp_w_q.push_back(w_exp(32'h87654321, 4'h0, 1'b0, 1'b0));
    exp_w_q.push_back(w_exp(32'h5A5A5A5A, 4'hF, 1'b0, 1'b1));
    exp_w_q.push_back(w_exp(32'hA5A5A5A5, 4'hF, 1'b1, 1'b1));
    exp_b_q.push_back({2'd3, 2'd1, 1'b0});
    fork
      begin
        do_aw(2'd3, 32'h6000, 8'd1, 3'd3);
        do_w(64'h87654321_0FEDCBA9, 8'h0F, 1'b0, 1'b0);
        do_w(64'hA5A5A5A5_5A5A5A5A, 8'hFF, 1'b1, 1'b1);
      end
      slave_run(4, -1, 0, 2'd3, 2'd1, 1'b0, 1'b1);
      master_b(0);
    join
    gap();

    check("queues_drained", 64'(exp_aw_q.size() + exp_w_q.size() + exp_b_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
